// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter reset value and saturating arithmetic.
// Values travel as 64-bit words so one set of functions serves every counter width.
package bp_pkg;

   function automatic logic [63:0] sat_max(input int unsigned w);
      return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

   // Weakly-not-taken: just below the taken threshold.
   function automatic logic [63:0] ctr_reset_val(input int unsigned bits);
      return (64'd1 << (bits - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      return (v == sat_max(w)) ? v : v + 64'd1;
   endfunction

   function automatic logic [63:0] sat_dec(input logic [63:0] v);
      return (v == 64'd0) ? v : v - 64'd1;
   endfunction

   function automatic logic [63:0] perf_sat_add(input logic [63:0] v, input int unsigned w,
                                                 input logic en);
      return en ? sat_inc(v, w) : v;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// One saturating up/down counter with an asynchronous reset value.
module sat_counter
   import bp_pkg::*;
#(
   parameter int unsigned        WIDTH     = 2,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= RESET_VAL;
      else if (en)
         q <= inc ? WIDTH'(sat_inc(64'(q), WIDTH)) : WIDTH'(sat_dec(64'(q)));
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters, bimodal or gshare-indexed, with
// combinational decode-time lookup, MEM-time training and saturating perf counters.
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned INDEX_BITS   = 6,
   parameter int unsigned HISTORY_BITS = 0,
   parameter int unsigned COUNTER_BITS = 2,
   parameter int unsigned PERF_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lookup_valid,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   input  logic [ADDR_WIDTH-1:0] lookup_offset,
   output logic                  predict_taken,
   output logic [ADDR_WIDTH-1:0] predict_target,
   output logic [INDEX_BITS-1:0] predict_index,
   input  logic                  update_valid,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  update_taken,
   input  logic                  update_mispredict,
   output logic [PERF_WIDTH-1:0] perf_branches,
   output logic [PERF_WIDTH-1:0] perf_mispredicts
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam logic [COUNTER_BITS-1:0] CTR_RST = COUNTER_BITS'(ctr_reset_val(COUNTER_BITS));

   logic [ENTRIES-1:0][COUNTER_BITS-1:0] ctr_q;
   logic [INDEX_BITS-1:0]                hist_index;

   generate
      if (HISTORY_BITS > 0) begin : g_ghr
         logic [HISTORY_BITS-1:0] ghr;
         // Truncating the concatenation drops the oldest outcome; also covers a 1-bit history.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               ghr <= '0;
            else if (update_valid)
               ghr <= HISTORY_BITS'({ghr, update_taken});
         end
         assign hist_index = INDEX_BITS'(ghr);
      end else begin : g_no_ghr
         assign hist_index = '0;
      end
   endgenerate

   assign predict_index  = lookup_pc[INDEX_BITS+1:2] ^ hist_index;
   assign predict_target = lookup_pc + lookup_offset;
   // Reads current flop state, so a same-cycle update is seen only on the next cycle.
   assign predict_taken  = lookup_valid & ctr_q[predict_index][COUNTER_BITS-1];

   generate
      for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
         sat_counter #(
            .WIDTH     (COUNTER_BITS),
            .RESET_VAL (CTR_RST)
         ) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (update_valid && (update_index == INDEX_BITS'(i))),
            .inc   (update_taken),
            .q     (ctr_q[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (update_valid) begin
         perf_branches    <= PERF_WIDTH'(perf_sat_add(64'(perf_branches), PERF_WIDTH, 1'b1));
         perf_mispredicts <= PERF_WIDTH'(perf_sat_add(64'(perf_mispredicts), PERF_WIDTH,
                                                      update_mispredict));
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal and a gshare instance share stimulus and are
// compared against a table/array model, with directed cases followed by random traffic.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lookup_valid;
   logic [31:0] lookup_pc, lookup_offset;
   logic        update_valid, update_taken, update_mispredict;
   logic [5:0]  update_index;

   logic        b_taken, g_taken;
   logic [31:0] b_target, g_target;
   logic [5:0]  b_index, g_index;
   logic [31:0] b_br, b_mp;
   logic [3:0]  g_br, g_mp;

   int n_chk = 0;
   int n_fail = 0;

   // Model: [0] bimodal, [1] gshare with 4 history bits and 4-bit perf counters.
   int          ctr [2][64];
   int          ghr;
   longint      br [2];
   longint      mp [2];
   longint      pmax [2] = '{64'hFFFF_FFFF, 15};

   always #5 clk = ~clk;

   branch_predictor_bht #(.HISTORY_BITS(0), .PERF_WIDTH(32)) u_bim (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .predict_taken(b_taken), .predict_target(b_target),
      .predict_index(b_index), .update_valid(update_valid), .update_index(update_index),
      .update_taken(update_taken), .update_mispredict(update_mispredict),
      .perf_branches(b_br), .perf_mispredicts(b_mp));

   branch_predictor_bht #(.HISTORY_BITS(4), .PERF_WIDTH(4)) u_gsh (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .predict_taken(g_taken), .predict_target(g_target),
      .predict_index(g_index), .update_valid(update_valid), .update_index(update_index),
      .update_taken(update_taken), .update_mispredict(update_mispredict),
      .perf_branches(g_br), .perf_mispredicts(g_mp));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 64; i++) ctr[g][i] = 1;
         br[g] = 0;
         mp[g] = 0;
      end
      ghr = 0;
   endfunction

   function automatic void model_update(input int idx, input logic t, input logic m);
      for (int g = 0; g < 2; g++) begin
         ctr[g][idx] = t ? ((ctr[g][idx] < 3) ? ctr[g][idx] + 1 : 3)
                         : ((ctr[g][idx] > 0) ? ctr[g][idx] - 1 : 0);
         if (br[g] < pmax[g]) br[g]++;
         if (m && mp[g] < pmax[g]) mp[g]++;
      end
      ghr = ((ghr * 2) + (t ? 1 : 0)) % 16;
   endfunction

   task automatic compare_all();
      int          pidx;
      logic [31:0] tgt;
      pidx = (lookup_pc / 4) % 64;
      tgt  = lookup_pc + lookup_offset;
      chk("bim_index", 64'(b_index), 64'(pidx));
      chk("bim_taken", 64'(b_taken), 64'(lookup_valid && ctr[0][pidx] >= 2));
      chk("bim_target", 64'(b_target), 64'(tgt));
      chk("bim_perf_br", 64'(b_br), 64'(br[0]));
      chk("bim_perf_mp", 64'(b_mp), 64'(mp[0]));
      chk("gsh_index", 64'(g_index), 64'(pidx ^ ghr));
      chk("gsh_taken", 64'(g_taken), 64'(lookup_valid && ctr[1][pidx ^ ghr] >= 2));
      chk("gsh_target", 64'(g_target), 64'(tgt));
      chk("gsh_perf_br", 64'(g_br), 64'(br[1]));
      chk("gsh_perf_mp", 64'(g_mp), 64'(mp[1]));
   endtask

   task automatic step(input logic lv, input logic [31:0] pc, input logic [31:0] off,
                       input logic uv, input int ui, input logic ut, input logic um);
      @(negedge clk);
      lookup_valid      = lv;
      lookup_pc         = pc;
      lookup_offset     = off;
      update_valid      = uv;
      update_index      = 6'(ui);
      update_taken      = ut;
      update_mispredict = um;
      #1 compare_all();
      @(posedge clk);
      if (uv && rst_n) model_update(ui, ut, um);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      update_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      lookup_valid = 1'b1; lookup_pc = 32'h100; lookup_offset = 32'h20;
      update_valid = 1'b0; update_index = '0; update_taken = 1'b0; update_mispredict = 1'b0;
      model_reset();
      #12;
      chk("rst_taken", 64'(b_taken), 64'd0);
      chk("rst_perf_br", 64'(b_br), 64'd0);
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: first lookup after reset
      step(1, 32'h100, 32'h20, 0, 0, 0, 0);
      chk("t1_target", 64'(b_target), 64'h120);
      chk("t1_index", 64'(b_index), 64'd0);
      chk("t1_taken", 64'(b_taken), 64'd0);

      // Test 2: saturation up and down on index 0
      step(0, 32'h100, 0, 1, 0, 1, 0);
      step(0, 32'h100, 0, 1, 0, 1, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t2_taken_after2", 64'(b_taken), 64'd1);
      step(0, 32'h100, 0, 1, 0, 1, 0);
      chk("t2_sat_hi", 64'(ctr[0][0]), 64'd3);
      step(1, 32'h100, 0, 1, 0, 0, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t2_one_nt", 64'(b_taken), 64'd1);
      step(1, 32'h100, 0, 1, 0, 0, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t2_two_nt", 64'(b_taken), 64'd0);

      // Test 3: read-before-write on index 5
      @(negedge clk);
      lookup_valid = 1'b1; lookup_pc = 32'h114; lookup_offset = 32'h0;
      update_valid = 1'b1; update_index = 6'd5; update_taken = 1'b1; update_mispredict = 1'b0;
      #1 chk("t3_same_cycle", 64'(b_taken), 64'd0);
      @(posedge clk);
      model_update(5, 1'b1, 1'b0);
      step(1, 32'h114, 0, 0, 0, 0, 0);
      chk("t3_next_cycle", 64'(b_taken), 64'd1);

      // Test 5: perf counters, 4-bit saturation on the gshare instance
      apply_reset();
      step(0, 0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1, 1);
      step(0, 0, 0, 1, 1, 0, 0);
      chk("t5_br3", 64'(g_br), 64'd3);
      chk("t5_mp1", 64'(g_mp), 64'd1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 2, i[0], 0);
      chk("t5_br_sat", 64'(g_br), 64'd15);
      chk("t5_mp_hold", 64'(g_mp), 64'd1);
      chk("t5_bim_br23", 64'(b_br), 64'd23);

      // Test 4: gshare history T,T,N,T
      apply_reset();
      step(0, 0, 0, 1, 7, 1, 0);
      step(0, 0, 0, 1, 7, 1, 0);
      step(0, 0, 0, 1, 7, 0, 0);
      step(0, 0, 0, 1, 7, 1, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t4_gsh_index", 64'(g_index), 64'd13);
      chk("t4_bim_index", 64'(b_index), 64'd0);

      // Test 6: asynchronous reset mid-cycle
      apply_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, 0);
      @(negedge clk);
      lookup_valid = 1'b1; lookup_pc = 32'h100; update_valid = 1'b0;
      #1 chk("t6_pre_taken", 64'(b_taken), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_taken", 64'(b_taken), 64'd0);
      chk("t6_async_br", 64'(b_br), 64'd0);
      chk("t6_async_gidx", 64'(g_index), 64'd0);
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("t6_after_release", 64'(b_taken), 64'd0);

      // Random traffic, narrow update index range to exercise saturation
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
              1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
